// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipe_skid_reg handshake stage: state encoding and
// the occupancy decode used by every handshake stage in the datapath.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int SIZE_DEFAULT = 32;

  function automatic logic [1:0] occ_of(state_e s);
    case (s)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Registered valid/ready pipeline stage with a one-entry skid slot, so in_ready
// never depends combinationally on out_ready. Sync flush squashes held words.
//
//  state    | meaning
//  ---------+------------------------------------------------
//  ST_EMPTY | nothing held, out_valid=0
//  ST_BUSY  | main word valid on out_data
//  ST_FULL  | main word on out_data plus one word in skid slot
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      occupancy
);

  state_e          state_q, state_d;
  logic [SIZE-1:0] main_q, main_d;
  logic [SIZE-1:0] skid_q, skid_d;
  logic            in_ready_q, in_ready_d;
  logic            accept, emit;

  assign accept = in_valid & in_ready_q;
  assign emit   = (state_q != ST_EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // an emit in this cycle still completes downstream; only held words are lost
      state_d = ST_EMPTY;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_BUSY;
            main_d  = in_data;
          end
        end
        ST_BUSY: begin
          if (accept && emit) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (emit) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = occ_of(state_q);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed steps followed by a long random run, all
// checked against a queue-based model of a two-deep FIFO stage.
module tb_pipe_skid_reg;

  localparam int SIZE = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [SIZE-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SIZE-1:0] out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [1:0]      occupancy;

  int vectors = 0;
  int miscompares = 0;

  logic [SIZE-1:0] q[$];
  bit              data_zero = 1'b1;

  pipe_skid_reg #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":occupancy"}, 32'(occupancy), 32'(q.size()));
    chk({tag, ":out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ":in_ready"},  32'(in_ready),  32'(q.size() < 2));
    if (q.size() > 0) chk({tag, ":out_data"}, out_data, q[0]);
    else if (data_zero) chk({tag, ":out_data_zero"}, out_data, 32'h0);
  endtask

  // Drive inputs, advance one edge while updating the model, sample on negedge.
  task automatic step(input bit r, input bit f, input bit iv,
                      input logic [SIZE-1:0] id, input bit ordy, input string tag);
    bit acc, emt;
    rst = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
    acc = iv && (q.size() < 2);
    emt = ordy && (q.size() > 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      data_zero = 1'b1;
    end else if (f) begin
      q.delete();
    end else begin
      if (emt) void'(q.pop_front());
      if (acc) begin
        q.push_back(id);
        data_zero = 1'b0;
      end
    end
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    bit iv, f, r, ordy, hold;
    logic [SIZE-1:0] id;

    // 1: reset
    step(1, 0, 0, 0, 0, "rst0");
    step(1, 0, 0, 0, 0, "rst1");
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 2: single word, one-cycle latency
    step(0, 0, 1, 32'hA5A5_0001, 1, "single");
    chk("single_data", out_data, 32'hA5A5_0001);
    chk("single_occ", 32'(occupancy), 32'd1);
    step(0, 0, 0, 0, 1, "single_drain");

    // 3: fill skid under stall, then drain in order
    step(0, 0, 1, 32'h11, 0, "stall_a");
    step(0, 0, 1, 32'h22, 0, "stall_b");
    chk("full_occ", 32'(occupancy), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_hold_data", out_data, 32'h11);
    step(0, 0, 1, 32'h22, 0, "stall_hold");
    chk("full_hold_data2", out_data, 32'h11);
    step(0, 0, 0, 0, 1, "drain_a");
    chk("drain_second", out_data, 32'h22);
    step(0, 0, 0, 0, 1, "drain_b");

    // 4: back-to-back stream
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 1, 32'(i), 1, "stream");
      chk("stream_data", out_data, 32'(i));
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    step(0, 0, 0, 0, 1, "stream_drain");

    // 5: flush from FULL with a same-cycle upstream word
    step(0, 0, 1, 32'h44, 0, "fl_a");
    step(0, 0, 1, 32'h55, 0, "fl_b");
    step(0, 1, 1, 32'h33, 0, "flush");
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, "post_flush");
      chk("post_flush_valid", 32'(out_valid), 32'd0);
    end

    // 6: random traffic with a mid-run reset; upstream holds its word while stalled
    iv = 1'b0; id = '0;
    for (int c = 0; c < 10000; c++) begin
      hold = iv && (q.size() >= 2);
      if (!hold) begin
        iv = ($urandom_range(0, 3) != 0);
        id = $urandom;
      end
      ordy = ($urandom_range(0, 2) != 0);
      f    = ($urandom_range(0, 31) == 0);
      r    = (c == 5000) || (c == 5001);
      step(r, f, iv, id, ordy, "rand");
      if (c == 5001) begin
        chk("midrst_occ", 32'(occupancy), 32'd0);
        chk("midrst_data", out_data, 32'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
